hpdcache_mem_write_responder: RTL and testbench
===============================================

# hpdcache_mem_write_responder

Synthesizable memory-side write target for the HPDcache verification environment. It consumes the write-request and write-data channels driven by the HPDcache write buffer and uncached write path, generating `ready` backpressure on both. It pairs each request with its data beats, issues byte-enabled writes to a memory-model port, and returns write responses on the response channel after a fixed latency. It replaces the testbench-level random-ready processes with a deterministic LFSR-based backpressure generator.

## Interface
Parameters:
- `ID_W`, 4: request/response ID width
- `ADDR_W`, 64: byte address width
- `DATA_W`, 64: data beat width; power of 2, ≥ 8
- `LEN_W`, 8: burst length field width (beats − 1)
- `REQ_DEPTH`, 4: request FIFO depth; power of 2, ≥ 2
- `RSP_DEPTH`, 4: maximum outstanding responses (pipeline plus FIFO)
- `RSP_LATENCY`, 2: cycles from last-beat handshake to response eligibility; ≥ 1
- `SEED_REQ`, 16'hACE1; `SEED_DATA`, 16'h1D2B: LFSR seeds; must be non-zero

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `bp_req_i` in 2: request-channel backpressure mode; 0 NEVER, 1 LIGHT, 2 MEDIUM, 3 HEAVY
- `bp_data_i` in 2: data-channel backpressure mode; same encoding
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake
- `req_addr_i` in ADDR_W: burst start byte address, aligned to DATA_W/8
- `req_len_i` in LEN_W: number of beats minus one
- `req_id_i` in ID_W: transaction ID
- `req_need_rsp_i` in 1: 1 means a response is returned
- `data_valid_i` in 1 / `data_ready_o` out 1: data handshake
- `data_i` in DATA_W: write data; `data_be_i` in DATA_W/8: byte enables; `data_last_i` in 1: final beat of the burst
- `mem_we_o` out 1; `mem_addr_o` out ADDR_W; `mem_wdata_o` out DATA_W; `mem_be_o` out DATA_W/8: memory-model write port
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: response handshake
- `rsp_id_o` out ID_W: response ID
- `rsp_error_o` out 1: burst length mismatch

## Operation
- **Backpressure generator:** one 16-bit Fibonacci LFSR per channel, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle. `stall` is registered and computed from the next LFSR value:
  - NEVER: stall = 0
  - LIGHT: stall = (lfsr[1:0]==2'b10)
  - MEDIUM: stall = (lfsr[3:0] ≥ 6)
  - HEAVY: stall = (lfsr[3:0] != 0)
- **Request FIFO** holds {addr, len, id, need_rsp}. `req_ready_o = !req_full && !stall_req`. There is no bypass.
- **Beat counter** `beat_cnt` (LEN_W bits) tracks progress through the head request.
- **Data acceptance:** `data_ready_o = !req_empty && (rsp_outstanding < RSP_DEPTH) && !stall_data`.
- **Memory write:** on each data handshake, `mem_we_o` pulses combinationally with:
  - `mem_addr_o = head.addr + beat_cnt*(DATA_W/8)`, modulo 2^ADDR_W
  - `mem_wdata_o`/`mem_be_o` = `data_i`/`data_be_i`
- **Burst end:** a beat ends the burst when `data_last_i` = 1.
  - On that beat, `error = (beat_cnt != head.len)`, the head is popped, and `beat_cnt` clears.
  - Beats with `beat_cnt == head.len` and `data_last_i` = 0 continue the same burst. `beat_cnt` saturates at all-ones, and the error is flagged at last.
- **Response path:** if `need_rsp`, {id, error} enters an RSP_LATENCY-stage shift pipeline, then a response FIFO.
  - `rsp_outstanding` counts pipeline plus FIFO entries. It increments at burst end, decrements on response handshake, and both may occur in the same cycle.
  - Responses are returned in completion order.
- **Reset** (any time, including mid-burst): all FIFOs, pipeline, counters and `beat_cnt` clear; LFSRs load their seeds; in-flight transactions are discarded.

## Timing
- **Reset values:**
  - `req_ready_o` = 0, `data_ready_o` = 0, `mem_we_o` = 0, `rsp_valid_o` = 0
  - `rsp_id_o`, `rsp_error_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o` = 0
  - Stall registers = 1
- **First cycle after reset release:** stall is updated from the seeded LFSR. With NEVER, `req_ready_o` = 1 from the second edge onward.
- **Request to data:** a request accepted at edge T allows its first data beat at edge T+1 at the earliest.
- **Last beat to response:** a last beat at edge T gives `rsp_valid_o` = 1 in the cycle after edge T+RSP_LATENCY, provided the response FIFO is empty. Responses are held stable until `rsp_ready_i`.
- **Full request FIFO:** simultaneous push and pop while full is not possible because ready is low; a pop frees the slot for the next cycle.
- **Credit exhausted:** when `rsp_outstanding == RSP_DEPTH`, `data_ready_o` = 0. A response handshake restores `data_ready_o` in the next cycle.
- **No-response requests** still consume a request slot but no response credit.

## Test plan
- NEVER/NEVER, request addr 0x1000, len 3, id 5, need_rsp 1, 4 beats with last on beat 3 -> `mem_addr_o` = 0x1000, 0x1008, 0x1010, 0x1018; response id 5, error 0, exactly 3 cycles after last beat (RSP_LATENCY 2).
- Request len 3 with last on beat 1 -> two writes, response error 1; the next request starts at its own address with `beat_cnt` 0.
- 5 requests pushed back-to-back, no data -> `req_ready_o` drops after 4 accepts and recovers the cycle after the first burst completes.
- `rsp_ready_i` = 0, five single-beat need_rsp bursts -> four complete, `data_ready_o` held 0; one `rsp_ready_i` pulse -> fifth beat accepted, IDs return in order.
- HEAVY on both channels, 1000 cycles of constant valid -> ready duty cycle within 6.25% ± 2%; identical ready trace across reruns with the same seeds.
- Reset asserted mid-burst (beat 2 of 4) -> all outputs 0 asynchronously; after release, a new burst completes with no stale response.

Source files
------------

// File: rtl/hpdcache_mem_write_responder.sv
// Memory-side write target: request/data channels with LFSR backpressure,
// byte-enabled memory-model writes and fixed-latency in-order responses.
// Ports: clk_i/rst_ni; bp_req_i/bp_data_i backpressure modes;
// req_* request channel; data_* write-data channel; mem_* memory-model
// write port; rsp_* response channel (id, length-mismatch error).
module hpdcache_mem_write_responder #(
  parameter int unsigned ID_W        = 4,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned REQ_DEPTH   = 4,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned RSP_LATENCY = 2,
  parameter logic [15:0] SEED_REQ    = 16'hACE1,
  parameter logic [15:0] SEED_DATA   = 16'h1D2B
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          bp_req_i,
  input  logic [1:0]          bp_data_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [LEN_W-1:0]    req_len_i,
  input  logic [ID_W-1:0]     req_id_i,
  input  logic                req_need_rsp_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic                data_last_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic                rsp_error_o
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned QP_W  = $clog2(REQ_DEPTH);
  localparam int unsigned QC_W  = $clog2(REQ_DEPTH + 1);
  localparam int unsigned SP_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned SC_W  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [ID_W-1:0]   id;
    logic              need_rsp;
  } req_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            err;
  } rsp_t;

  // x^16+x^14+x^13+x^11+1, right-shifting form
  function automatic logic [15:0] lfsr_nxt(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic stall_of(input logic [1:0] m,
                                    input logic [15:0] s);
    logic st;
    unique case (m)
      2'd0:    st = 1'b0;
      2'd1:    st = (s[1:0] == 2'b10);
      2'd2:    st = (s[3:0] >= 4'd6);
      default: st = (s[3:0] != 4'd0);
    endcase
    return st;
  endfunction

  function automatic logic [SP_W-1:0] sp_inc(input logic [SP_W-1:0] p);
    return (p == SP_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [15:0]      lfsr_req_q, lfsr_req_d;
  logic [15:0]      lfsr_dat_q, lfsr_dat_d;
  logic             stall_req_q, stall_dat_q;
  req_t             rq_mem_q [REQ_DEPTH];
  logic [QP_W-1:0]  rq_wr_q, rq_rd_q;
  logic [QC_W-1:0]  rq_cnt_q;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  rsp_t             pipe_q [RSP_LATENCY];
  logic [ID_W:0]    rs_mem_q [RSP_DEPTH];
  logic [SP_W-1:0]  rs_wr_q, rs_rd_q;
  logic [SC_W-1:0]  rs_cnt_q;
  logic [SC_W-1:0]  rsp_out_q;

  req_t head;
  logic rq_push, rq_pop, dat_hs, burst_err, rsp_in;
  logic rs_push, rs_pop;

  assign lfsr_req_d = lfsr_nxt(lfsr_req_q);
  assign lfsr_dat_d = lfsr_nxt(lfsr_dat_q);

  assign head = rq_mem_q[rq_rd_q];

  assign req_ready_o  = (rq_cnt_q != QC_W'(REQ_DEPTH)) && !stall_req_q;
  assign rq_push      = req_valid_i && req_ready_o;
  assign data_ready_o = (rq_cnt_q != '0)
                     && (rsp_out_q < SC_W'(RSP_DEPTH))
                     && !stall_dat_q;
  assign dat_hs       = data_valid_i && data_ready_o;
  assign rq_pop       = dat_hs && data_last_i;
  assign burst_err    = (beat_cnt_q != head.len);
  assign rsp_in       = rq_pop && head.need_rsp;

  // Counter stops at all-ones for overlong bursts; last clears it.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (rq_pop) beat_cnt_d = '0;
    else if (dat_hs && beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
  end

  assign mem_we_o    = dat_hs;
  assign mem_addr_o  = dat_hs
                     ? head.addr + (ADDR_W'(beat_cnt_q) << OFF_W)
                     : '0;
  assign mem_wdata_o = dat_hs ? data_i : '0;
  assign mem_be_o    = dat_hs ? data_be_i : '0;

  assign rs_push     = pipe_q[RSP_LATENCY-1].vld;
  assign rsp_valid_o = (rs_cnt_q != '0);
  assign rs_pop      = rsp_valid_o && rsp_ready_i;
  assign rsp_id_o    = rsp_valid_o ? rs_mem_q[rs_rd_q][ID_W:1] : '0;
  assign rsp_error_o = rsp_valid_o && rs_mem_q[rs_rd_q][0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_req_q  <= SEED_REQ;
      lfsr_dat_q  <= SEED_DATA;
      stall_req_q <= 1'b1;
      stall_dat_q <= 1'b1;
    end else begin
      lfsr_req_q  <= lfsr_req_d;
      lfsr_dat_q  <= lfsr_dat_d;
      stall_req_q <= stall_of(bp_req_i, lfsr_req_d);
      stall_dat_q <= stall_of(bp_data_i, lfsr_dat_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REQ_DEPTH; i++) rq_mem_q[i] <= '0;
      rq_wr_q    <= '0;
      rq_rd_q    <= '0;
      rq_cnt_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (rq_push) begin
        rq_mem_q[rq_wr_q] <= '{addr: req_addr_i, len: req_len_i,
                               id: req_id_i, need_rsp: req_need_rsp_i};
        rq_wr_q <= rq_wr_q + 1'b1;
      end
      if (rq_pop) rq_rd_q <= rq_rd_q + 1'b1;
      rq_cnt_q   <= rq_cnt_q + QC_W'(rq_push) - QC_W'(rq_pop);
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Credits cover pipeline plus FIFO, so the FIFO can never overflow
  // and the pipeline never needs to stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RSP_LATENCY; i++) pipe_q[i] <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) rs_mem_q[i] <= '0;
      rs_wr_q   <= '0;
      rs_rd_q   <= '0;
      rs_cnt_q  <= '0;
      rsp_out_q <= '0;
    end else begin
      pipe_q[0] <= '{vld: rsp_in, id: head.id, err: burst_err};
      for (int i = 1; i < RSP_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      if (rs_push) begin
        rs_mem_q[rs_wr_q] <= {pipe_q[RSP_LATENCY-1].id,
                              pipe_q[RSP_LATENCY-1].err};
        rs_wr_q <= sp_inc(rs_wr_q);
      end
      if (rs_pop) rs_rd_q <= sp_inc(rs_rd_q);
      rs_cnt_q  <= rs_cnt_q + SC_W'(rs_push) - SC_W'(rs_pop);
      rsp_out_q <= rsp_out_q + SC_W'(rsp_in) - SC_W'(rs_pop);
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_write_responder.sv
// Bench for hpdcache_mem_write_responder: vector table for the basic
// burst/response flow plus directed multi-cycle sequences.
module tb_hpdcache_mem_write_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  bp_req, bp_data;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [3:0]  req_id;
  logic        req_need;
  logic        data_valid, data_ready;
  logic [63:0] data;
  logic [7:0]  data_be;
  logic        data_last;
  logic        mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_id;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hpdcache_mem_write_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .bp_req_i(bp_req), .bp_data_i(bp_data),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .req_id_i(req_id), .req_need_rsp_i(req_need),
    .data_valid_i(data_valid), .data_ready_o(data_ready),
    .data_i(data), .data_be_i(data_be), .data_last_i(data_last),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_error_o(rsp_error)
  );

  typedef struct packed {
    logic        rv;
    logic [63:0] ra;
    logic [7:0]  rl;
    logic [3:0]  rid;
    logic        dv;
    logic        dl;
    logic        rr;
    logic        e_rr;
    logic        e_dr;
    logic        e_we;
    logic [63:0] e_ma;
    logic        e_rv;
    logic [3:0]  e_id;
    logic        e_er;
  } vec_t;

  vec_t v [18];

  function automatic vec_t mk(
    logic rv, logic [63:0] ra, logic [7:0] rl, logic [3:0] rid,
    logic dv, logic dl, logic rr,
    logic e_rr, logic e_dr, logic e_we, logic [63:0] e_ma,
    logic e_rv, logic [3:0] e_id, logic e_er);
    vec_t r;
    r = '{rv: rv, ra: ra, rl: rl, rid: rid, dv: dv, dl: dl, rr: rr,
          e_rr: e_rr, e_dr: e_dr, e_we: e_we, e_ma: e_ma,
          e_rv: e_rv, e_id: e_id, e_er: e_er};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    req_valid = 0; req_addr = 0; req_len = 0; req_id = 0; req_need = 0;
    data_valid = 0; data = 0; data_be = 0; data_last = 0;
    rsp_ready = 0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_rsp(output bit got);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rsp_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic duty(input logic [1:0] br, input logic [1:0] bd,
                      input bit meas_data, output int cnt,
                      output logic [31:0] sig);
    logic r;
    bp_req = br;
    bp_data = bd;
    do_reset();
    req_valid = 1; req_addr = 64'h8000; req_len = 0; req_need = 0;
    data_valid = 1; data_last = 1; data_be = 8'hFF; rsp_ready = 1;
    cnt = 0;
    sig = 32'h1;
    for (int i = 0; i < 1000; i++) begin
      #1;
      r = meas_data ? data_ready : req_ready;
      cnt += int'(r);
      sig = {sig[30:0], sig[31] ^ r};
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    bit got;
    bit stale;
    int c1, c2;
    logic [31:0] s1, s2;

    v[0]  = mk(1, 'h1000, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[1]  = mk(1, 'h1000, 3, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v[2]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 'h1000, 0, 0, 0);
    v[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 'h1008, 0, 0, 0);
    v[4]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 'h1010, 0, 0, 0);
    v[5]  = mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 'h1018, 0, 0, 0);
    v[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 0);
    v[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 5, 0);
    v[10] = mk(1, 'h2000, 3, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v[11] = mk(1, 'h3000, 0, 7, 1, 0, 0, 1, 1, 1, 'h2000, 0, 0, 0);
    v[12] = mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 'h2008, 0, 0, 0);
    v[13] = mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 'h3000, 0, 0, 0);
    v[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 6, 1);
    v[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 7, 0);
    v[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // reset values with busy inputs
    bp_req = 0; bp_data = 0; rst_n = 0;
    idle();
    req_valid = 1; data_valid = 1; data = '1; data_be = '1;
    data_last = 1; rsp_ready = 1;
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_error", rsp_error, 0);
    @(negedge clk);
    idle();
    rst_n = 1;

    // vector table: normal burst, short burst with error, single beat
    for (int i = 0; i < 18; i++) begin
      req_valid = v[i].rv; req_addr = v[i].ra; req_len = v[i].rl;
      req_id = v[i].rid; req_need = 1;
      data_valid = v[i].dv; data_last = v[i].dl;
      data = 64'hD000 + 64'(i); data_be = 8'h81 | 8'(i);
      rsp_ready = v[i].rr;
      #1;
      chk($sformatf("row%0d_req_ready", i), req_ready, v[i].e_rr);
      chk($sformatf("row%0d_data_ready", i), data_ready, v[i].e_dr);
      chk($sformatf("row%0d_mem_we", i), mem_we, v[i].e_we);
      chk($sformatf("row%0d_mem_addr", i), mem_addr, v[i].e_ma);
      chk($sformatf("row%0d_mem_wdata", i), mem_wdata,
          v[i].e_we ? 64'hD000 + 64'(i) : 64'h0);
      chk($sformatf("row%0d_mem_be", i), mem_be,
          v[i].e_we ? 64'(8'h81 | 8'(i)) : 64'h0);
      chk($sformatf("row%0d_rsp_valid", i), rsp_valid, v[i].e_rv);
      chk($sformatf("row%0d_rsp_id", i), rsp_id, v[i].e_id);
      chk($sformatf("row%0d_rsp_error", i), rsp_error, v[i].e_er);
      @(negedge clk);
    end
    idle();

    // request FIFO full, then recovery after one pop
    do_reset();
    @(negedge clk);
    req_valid = 1; req_addr = 64'h100; req_len = 0; req_need = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("full_req_ready%0d", k), req_ready, k < 4);
      @(negedge clk);
    end
    data_valid = 1; data_last = 1; data_be = 8'hFF;
    #1;
    chk("full_pop_data_ready", data_ready, 1);
    chk("full_pop_req_ready", req_ready, 0);
    @(negedge clk);
    data_valid = 0;
    #1;
    chk("full_recover_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    data_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("full_drain%0d", k), data_ready, 1);
      @(negedge clk);
    end
    data_valid = 0;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (rsp_valid || data_ready) stale = 1;
      @(negedge clk);
    end
    chk("norsp_no_response", stale, 0);
    idle();

    // response credit exhaustion
    do_reset();
    @(negedge clk);
    req_valid = 1; req_len = 0; req_need = 1;
    for (int k = 1; k <= 4; k++) begin
      req_id = 4'(k); req_addr = 64'(k) << 8;
      #1;
      chk($sformatf("cred_push%0d", k), req_ready, 1);
      @(negedge clk);
    end
    req_valid = 0;
    data_valid = 1; data_last = 1; data_be = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cred_beat%0d", k), data_ready, 1);
      @(negedge clk);
    end
    req_valid = 1; req_id = 5; req_addr = 64'h500;
    #1;
    chk("cred_push5", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (data_ready) stale = 1;
      @(negedge clk);
    end
    chk("cred_blocked", stale, 0);
    rsp_ready = 1;
    #1;
    chk("cred_rsp_valid", rsp_valid, 1);
    chk("cred_rsp_id1", rsp_id, 1);
    @(negedge clk);
    rsp_ready = 0;
    #1;
    chk("cred_restored", data_ready, 1);
    @(negedge clk);
    data_valid = 0;
    rsp_ready = 1;
    for (int k = 2; k <= 5; k++) begin
      wait_rsp(got);
      chk($sformatf("cred_got%0d", k), got, 1);
      chk($sformatf("cred_rsp_id%0d", k), rsp_id, 64'(k));
      @(negedge clk);
    end
    idle();

    // HEAVY backpressure duty cycle and repeatability
    duty(2'd3, 2'd0, 0, c1, s1);
    chk("heavy_req_duty_lo", c1 >= 43, 1);
    chk("heavy_req_duty_hi", c1 <= 82, 1);
    duty(2'd3, 2'd0, 0, c2, s2);
    chk("heavy_req_rerun", s2, s1);
    duty(2'd0, 2'd3, 1, c1, s1);
    chk("heavy_data_duty_lo", c1 >= 43, 1);
    chk("heavy_data_duty_hi", c1 <= 82, 1);
    duty(2'd0, 2'd3, 1, c2, s2);
    chk("heavy_data_rerun", s2, s1);
    bp_req = 0; bp_data = 0;

    // asynchronous reset in the middle of a burst
    do_reset();
    @(negedge clk);
    req_valid = 1; req_addr = 64'h4000; req_len = 3; req_id = 9;
    req_need = 1;
    @(negedge clk);
    req_valid = 0;
    data_valid = 1; data_last = 0; data_be = 8'hFF; data = 64'h55;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_beat2_addr", mem_addr, 64'h4010);
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_data_ready", data_ready, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    req_valid = 1; req_addr = 64'h5000; req_len = 0; req_id = 3;
    req_need = 1;
    #1;
    chk("post_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    data_valid = 1; data_last = 1; data_be = 8'hFF;
    #1;
    chk("post_mem_addr", mem_addr, 64'h5000);
    @(negedge clk);
    data_valid = 0;
    rsp_ready = 1;
    wait_rsp(got);
    chk("post_got", got, 1);
    chk("post_rsp_id", rsp_id, 3);
    chk("post_rsp_error", rsp_error, 0);
    @(negedge clk);
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp_valid) stale = 1;
      @(negedge clk);
    end
    chk("post_no_stale", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
